// File: rtl/motor_pwm_if.sv
// Command and status bundle between the command decode logic
// and the multi-channel H-bridge motor driver.
interface motor_pwm_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 12
);
    logic [NCH-1:0]       enable;
    logic [NCH*CNT_W-1:0] cmd_duty;
    logic [NCH-1:0]       cmd_dir;
    logic [NCH-1:0]       oc_sense;
    logic                 fault_clr;
    logic [NCH-1:0]       pwm_out;
    logic [NCH-1:0]       dir_a;
    logic [NCH-1:0]       dir_b;
    logic [NCH-1:0]       fault;
    logic [NCH*CNT_W-1:0] cur_duty;
    logic                 period_start;

    modport master (
        output enable, cmd_duty, cmd_dir,
        output oc_sense, fault_clr,
        input  pwm_out, dir_a, dir_b,
        input  fault, cur_duty, period_start
    );

    modport slave (
        input  enable, cmd_duty, cmd_dir,
        input  oc_sense, fault_clr,
        output pwm_out, dir_a, dir_b,
        output fault, cur_duty, period_start
    );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// NCH-channel H-bridge PWM driver: slew-limited duty, safe reversal
// through brake and dead time, latched per-channel overcurrent trip.
module motor_pwm_ctrl #(
    parameter int NCH          = 2,
    parameter int CNT_W        = 12,
    parameter int PERIOD       = 2500,
    parameter int RAMP_STEP    = 125,
    parameter int DEAD_PERIODS = 2,
    parameter int OC_LIMIT     = 2499
) (
    input logic       clk,
    input logic       rst_n,
    motor_pwm_if.slave bus
);
    localparam int OC_W = $clog2(OC_LIMIT + 1);
    localparam int DW   = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    localparam logic [CNT_W-1:0] PER  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);
    localparam logic [OC_W-1:0]  OC_L = OC_W'(OC_LIMIT);
    localparam logic [DW-1:0]    DLST = DW'(DEAD_PERIODS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_BRAKE,
        S_DEAD,
        S_FAULT
    } state_t;

    logic [CNT_W-1:0] cnt_q;
    logic             ps_q;
    logic             boundary;

    state_t           st_q   [NCH];
    state_t           st_d   [NCH];
    logic [CNT_W-1:0] duty_q [NCH];
    logic [CNT_W-1:0] duty_d [NCH];
    logic [DW-1:0]    dead_q [NCH];
    logic [DW-1:0]    dead_d [NCH];
    logic [OC_W-1:0]  oc_cnt [NCH];
    logic [NCH-1:0]   dir_q, dir_d;
    logic [NCH-1:0]   pwm_q, pwm_d;
    logic [NCH-1:0]   oc_s1, oc_s2;

    logic [CNT_W-1:0] tgt  [NCH];
    logic [CNT_W-1:0] down [NCH];
    logic [CNT_W-1:0] slew [NCH];
    logic [NCH-1:0]   trip, act;

    assign boundary = (cnt_q == LAST);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tgt[i] = '0;
            if (bus.enable[i]) begin
                if (bus.cmd_duty[i*CNT_W +: CNT_W] > PER)
                    tgt[i] = PER;
                else
                    tgt[i] = bus.cmd_duty[i*CNT_W +: CNT_W];
            end
            down[i] = (duty_q[i] > STEP) ? duty_q[i] - STEP : '0;
            if (tgt[i] > duty_q[i])
                slew[i] = (tgt[i] - duty_q[i] > STEP)
                        ? duty_q[i] + STEP : tgt[i];
            else
                slew[i] = (duty_q[i] - tgt[i] > STEP)
                        ? duty_q[i] - STEP : tgt[i];
            trip[i] = (oc_cnt[i] == OC_L);
            act[i]  = (st_q[i] == S_RUN) || (st_q[i] == S_BRAKE);
        end
    end

    // Trip overrides everything; clear is only reachable with trip low,
    // which with a saturating counter also means the count is below limit.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]   = st_q[i];
            duty_d[i] = duty_q[i];
            dead_d[i] = dead_q[i];
            dir_d[i]  = dir_q[i];
            pwm_d[i]  = !trip[i] && act[i] && (cnt_q < duty_q[i]);
            if (trip[i]) begin
                st_d[i]   = S_FAULT;
                duty_d[i] = '0;
            end else if (st_q[i] == S_FAULT) begin
                if (bus.fault_clr && !oc_s2[i]) begin
                    st_d[i]   = S_IDLE;
                    duty_d[i] = '0;
                end
            end else if (boundary) begin
                unique case (st_q[i])
                    S_IDLE: begin
                        if (tgt[i] != '0) begin
                            dir_d[i] = bus.cmd_dir[i];
                            st_d[i]  = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (bus.cmd_dir[i] != dir_q[i]) begin
                            duty_d[i] = down[i];
                            dead_d[i] = '0;
                            st_d[i]   = (down[i] == '0) ? S_DEAD : S_BRAKE;
                        end else if (tgt[i] == '0 && duty_q[i] == '0) begin
                            st_d[i] = S_IDLE;
                        end else begin
                            duty_d[i] = slew[i];
                        end
                    end
                    S_BRAKE: begin
                        duty_d[i] = down[i];
                        if (down[i] == '0) begin
                            dead_d[i] = '0;
                            st_d[i]   = S_DEAD;
                        end
                    end
                    S_DEAD: begin
                        if (dead_q[i] == DLST) begin
                            dir_d[i] = bus.cmd_dir[i];
                            st_d[i]  = (tgt[i] != '0) ? S_RUN : S_IDLE;
                        end else begin
                            dead_d[i] = dead_q[i] + DW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ps_q  <= 1'b0;
            dir_q <= '0;
            pwm_q <= '0;
            oc_s1 <= '0;
            oc_s2 <= '0;
            for (int i = 0; i < NCH; i++) begin
                st_q[i]   <= S_IDLE;
                duty_q[i] <= '0;
                dead_q[i] <= '0;
                oc_cnt[i] <= '0;
            end
        end else begin
            cnt_q <= boundary ? '0 : cnt_q + CNT_W'(1);
            ps_q  <= boundary;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            oc_s1 <= bus.oc_sense;
            oc_s2 <= oc_s1;
            for (int i = 0; i < NCH; i++) begin
                st_q[i]   <= st_d[i];
                duty_q[i] <= duty_d[i];
                dead_q[i] <= dead_d[i];
                if (!oc_s2[i])
                    oc_cnt[i] <= '0;
                else if (oc_cnt[i] != OC_L)
                    oc_cnt[i] <= oc_cnt[i] + OC_W'(1);
            end
        end
    end

    always_comb begin
        bus.pwm_out      = pwm_q;
        bus.period_start = ps_q;
        bus.dir_a        = '0;
        bus.dir_b        = '0;
        bus.fault        = '0;
        bus.cur_duty     = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.dir_a[i] = act[i] && dir_q[i];
            bus.dir_b[i] = act[i] && !dir_q[i];
            bus.fault[i] = (st_q[i] == S_FAULT);
            bus.cur_duty[i*CNT_W +: CNT_W] = duty_q[i];
        end
    end
endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Randomised and directed bench for motor_pwm_ctrl against a
// period-level behavioural model of the channel rules.
module tb_motor_pwm_ctrl;
    localparam int NCH  = 2;
    localparam int W    = 12;
    localparam int P    = 250;
    localparam int STEP = 25;
    localparam int DP   = 2;
    localparam int L    = 249;

    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MB = 2;
    localparam int MD = 3;
    localparam int MF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    motor_pwm_if #(.NCH(NCH), .CNT_W(W)) bus ();

    motor_pwm_ctrl #(
        .NCH(NCH), .CNT_W(W), .PERIOD(P), .RAMP_STEP(STEP),
        .DEAD_PERIODS(DP), .OC_LIMIT(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int n = 0;

    int m_mode [NCH];
    int m_duty [NCH];
    int m_dir  [NCH];
    int m_dead [NCH];
    int run_h  [NCH][4];
    logic [NCH-1:0] exp_pwm;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s n=%0d got=%0h exp=%0h",
                     tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        exp_pwm = '0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = MI;
            m_duty[c] = 0;
            m_dir[c]  = 0;
            m_dead[c] = 0;
            for (int d = 0; d < 4; d++) run_h[c][d] = 0;
        end
    endtask

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic enter_dead(int c);
        m_mode[c] = MD;
        m_dead[c] = DP;
    endtask

    // Period-boundary rules for one channel.
    task automatic boundary(int c);
        int cmd, tgt, cdir;
        cmd  = int'(bus.cmd_duty[c*W +: W]);
        tgt  = bus.enable[c] ? imin(cmd, P) : 0;
        cdir = int'(bus.cmd_dir[c]);
        case (m_mode[c])
            MI: if (tgt > 0) begin
                m_dir[c]  = cdir;
                m_mode[c] = MR;
            end
            MR: begin
                if (cdir != m_dir[c]) begin
                    m_duty[c] = imax(m_duty[c] - STEP, 0);
                    if (m_duty[c] == 0) enter_dead(c);
                    else m_mode[c] = MB;
                end else if (tgt == 0 && m_duty[c] == 0) begin
                    m_mode[c] = MI;
                end else if (tgt > m_duty[c]) begin
                    m_duty[c] = imin(tgt, m_duty[c] + STEP);
                end else begin
                    m_duty[c] = imax(tgt, m_duty[c] - STEP);
                end
            end
            MB: begin
                m_duty[c] = imax(m_duty[c] - STEP, 0);
                if (m_duty[c] == 0) enter_dead(c);
            end
            MD: begin
                m_dead[c]--;
                if (m_dead[c] == 0) begin
                    m_dir[c]  = cdir;
                    m_mode[c] = (tgt > 0) ? MR : MI;
                end
            end
            default: ;
        endcase
    endtask

    // One clock edge: inputs seen by the edge are the current drives.
    // run_h[c][d] = length of the high run ending d samples ago.
    task automatic model_edge();
        int k;
        bit trip, sync_hi, clr_ok;
        k = (n - 1) % P;
        for (int c = 0; c < NCH; c++) begin
            for (int d = 3; d > 0; d--) run_h[c][d] = run_h[c][d-1];
            run_h[c][0] = bus.oc_sense[c] ? run_h[c][1] + 1 : 0;
            trip    = run_h[c][3] >= L;
            sync_hi = run_h[c][2] > 0;
            clr_ok  = !sync_hi && run_h[c][3] < L;
            exp_pwm[c] = !trip && (m_mode[c] == MR || m_mode[c] == MB)
                         && (k < m_duty[c]);
            if (trip) begin
                m_mode[c] = MF;
                m_duty[c] = 0;
            end else if (m_mode[c] == MF) begin
                if (bus.fault_clr && clr_ok) m_mode[c] = MI;
            end else if (k == P - 1) begin
                boundary(c);
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0] ea, eb, ef;
        logic [NCH*W-1:0] ed;
        @(posedge clk);
        n++;
        @(negedge clk);
        model_edge();
        for (int c = 0; c < NCH; c++) begin
            ea[c] = (m_mode[c] == MR || m_mode[c] == MB) && m_dir[c] == 1;
            eb[c] = (m_mode[c] == MR || m_mode[c] == MB) && m_dir[c] == 0;
            ef[c] = (m_mode[c] == MF);
            ed[c*W +: W] = W'(m_duty[c]);
        end
        check("period_start", 64'(bus.period_start), 64'(n % P == 0));
        check("pwm", 64'(bus.pwm_out), 64'(exp_pwm));
        check("dir_a", 64'(bus.dir_a), 64'(ea));
        check("dir_b", 64'(bus.dir_b), 64'(eb));
        check("fault", 64'(bus.fault), 64'(ef));
        check("cur_duty", 64'(bus.cur_duty), 64'(ed));
    endtask

    task automatic periods(int np);
        repeat (np * P) step();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_pwm"}, 64'(bus.pwm_out), 64'(0));
        check({tag, "_dir"}, 64'({bus.dir_a, bus.dir_b}), 64'(0));
        check({tag, "_flt"}, 64'(bus.fault), 64'(0));
        check({tag, "_duty"}, 64'(bus.cur_duty), 64'(0));
        check({tag, "_ps"}, 64'(bus.period_start), 64'(0));
    endtask

    task automatic set_duty(int c, int v);
        bus.cmd_duty[c*W +: W] = W'(v);
    endtask

    int cnt, lat, guard;

    initial begin
        bus.enable    = '0;
        bus.cmd_duty  = '0;
        bus.cmd_dir   = '0;
        bus.oc_sense  = '0;
        bus.fault_clr = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        model_reset();

        // Forward ramp to half duty.
        bus.enable[0]  = 1'b1;
        bus.cmd_dir[0] = 1'b1;
        set_duty(0, P / 2);
        periods(7);
        check("ramp_end", 64'(bus.cur_duty[W-1:0]), 64'(P / 2));
        check("fwd_dir", 64'({bus.dir_a[0], bus.dir_b[0]}), 64'(2'b10));
        cnt = 0;
        repeat (P) begin
            step();
            cnt += int'(bus.pwm_out[0]);
        end
        check("hi_count", 64'(cnt), 64'(P / 2));

        // Reversal: brake ramp, then exactly DP dead periods.
        bus.cmd_dir[0] = 1'b0;
        periods(5);
        cnt = (bus.dir_a[0] | bus.dir_b[0] | bus.pwm_out[0]) ? 0 : 1;
        repeat (DP * P) begin
            step();
            if (!(bus.dir_a[0] | bus.dir_b[0] | bus.pwm_out[0])) cnt++;
        end
        check("dead_len", 64'(cnt), 64'(DP * P));
        check("rev_dir", 64'({bus.dir_a[0], bus.dir_b[0]}), 64'(2'b01));
        periods(6);
        check("rev_ramp", 64'(bus.cur_duty[W-1:0]), 64'(P / 2));

        // Over-range command clamps to full period.
        set_duty(0, 4000);
        periods(8);
        check("clamp", 64'(bus.cur_duty[W-1:0]), 64'(P));
        cnt = 0;
        repeat (P) begin
            step();
            cnt += int'(bus.pwm_out[0]);
        end
        check("full_on", 64'(cnt), 64'(P));

        // Overcurrent on channel 1.
        bus.enable[1]  = 1'b1;
        bus.cmd_dir[1] = 1'b1;
        set_duty(1, 200);
        periods(10);
        bus.oc_sense[1] = 1'b1;
        repeat (L - 1) step();
        bus.oc_sense[1] = 1'b0;
        repeat (20) step();
        check("oc_short", 64'(bus.fault[1]), 64'(0));
        bus.oc_sense[1] = 1'b1;
        lat = 0;
        while (!bus.fault[1] && lat < 2 * L) begin
            step();
            lat++;
        end
        check("oc_latency", 64'(lat), 64'(L + 3));
        check("oc_pwm", 64'(bus.pwm_out[1]), 64'(0));
        check("ch0_free", 64'(bus.fault[0]), 64'(0));
        bus.fault_clr = 1'b1;
        repeat (10) step();
        check("clr_ignored", 64'(bus.fault[1]), 64'(1));
        bus.fault_clr   = 1'b0;
        bus.oc_sense[1] = 1'b0;
        repeat (5) step();
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check("clr_done", 64'(bus.fault[1]), 64'(0));
        guard = 0;
        do begin
            step();
            guard++;
        end while (n % P != 0 && guard < 2 * P);
        check("restart0", 64'(bus.cur_duty[2*W-1:W]), 64'(0));
        periods(1);
        check("restart1", 64'(bus.cur_duty[2*W-1:W]), 64'(STEP));
        periods(3);

        // Random commands, faults and clears.
        repeat (60 * P) begin
            step();
            if ($urandom_range(149) == 0) begin
                bus.enable  = NCH'($urandom);
                bus.cmd_dir = NCH'($urandom);
                for (int c = 0; c < NCH; c++)
                    set_duty(c, int'($urandom_range(0, 2 * P)));
            end
            if ($urandom_range(299) == 0)
                bus.oc_sense[$urandom_range(NCH - 1)] ^= 1'b1;
            bus.fault_clr = ($urandom_range(39) == 0);
        end
        bus.oc_sense  = '0;
        bus.fault_clr = 1'b1;
        repeat (10) step();
        bus.fault_clr = 1'b0;

        // Reset asserted mid-period while braking.
        bus.enable[0]  = 1'b1;
        bus.cmd_dir[0] = 1'b1;
        set_duty(0, P);
        guard = 0;
        while (!(m_mode[0] == MR && m_duty[0] == P) && guard < 40 * P) begin
            step();
            guard++;
        end
        check("pre_brake", 64'(bus.cur_duty[W-1:0]), 64'(P));
        bus.cmd_dir[0] = 1'b0;
        guard = 0;
        while (m_mode[0] != MB && guard < 3 * P) begin
            step();
            guard++;
        end
        repeat (37) step();
        check("in_brake", 64'({bus.dir_a[0], bus.cur_duty[W-1:0] < P}),
              64'(2'b11));
        rst_n = 1'b0;
        #1;
        check_all_zero("brk_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        periods(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
